// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - LFSR/MISR built-in self-test sequencer for a combinational gate model
// Optional debug observation ports are enabled by defining GATE_BIST_DEBUG_EN.
module gate_bist_ctrl #(
    parameter int               IN_W       = 23,
    parameter int               OUT_W      = 10,
    parameter int               SIG_W      = 16,
    parameter logic [IN_W-1:0]  LFSR_TAPS  = 23'h420000,
    parameter logic [IN_W-1:0]  LFSR_SEED  = 23'h000001,
    parameter logic [SIG_W-1:0] MISR_TAPS  = 16'hB400,
    parameter int               PAT_CNT    = 1024,
    parameter int               SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass
`ifdef GATE_BIST_DEBUG_EN
    ,
    output logic [SIG_W-1:0] dbg_sig,
    output logic [15:0]      dbg_pat,
    output logic [15:0]      dbg_fail_first
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [IN_W-1:0] SEED      = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
    localparam logic [15:0]     PAT_LAST  = 16'(PAT_CNT);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE_CYC);

    state_t           state_q, state_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [15:0]      pat_q, pat_d;
    logic [15:0]      pat_inc;
    logic [3:0]       settle_q, settle_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
`ifdef GATE_BIST_DEBUG_EN
    logic [15:0]      fail_first_q, fail_first_d;
`endif

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        sig_d    = sig_q;
        pat_d    = pat_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        pat_inc  = pat_q + 16'd1;
`ifdef GATE_BIST_DEBUG_EN
        fail_first_d = fail_first_q;
`endif
        // Abort wins over every other transition and never touches pass.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            dut_in_d = '0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dut_in_d = '0;
                    if (start) begin
                        state_d  = S_SETTLE;
                        dut_in_d = SEED;
                        sig_d    = '0;
                        pat_d    = '0;
                        settle_d = SETTLE_LD;
                        busy_d   = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    sig_d = {sig_q[SIG_W-2:0], ^(sig_q & MISR_TAPS)} ^ SIG_W'(dut_out);
                    pat_d = pat_inc;
                    if (pat_inc == PAT_LAST) begin
                        state_d = S_COMPARE;
                    end else begin
                        dut_in_d = {dut_in_q[IN_W-2:0], ^(dut_in_q & LFSR_TAPS)};
                        settle_d = SETTLE_LD;
                        state_d  = S_SETTLE;
                    end
                end
                S_COMPARE: begin
                    pass_d  = (sig_q == golden_sig);
`ifdef GATE_BIST_DEBUG_EN
                    if (sig_q != golden_sig) begin
                        fail_first_d = pat_q;
                    end
`endif
                    state_d = S_DONE;
                end
                S_DONE: begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    dut_in_d = '0;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d  = S_IDLE;
                    dut_in_d = '0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            sig_q    <= '0;
            pat_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef GATE_BIST_DEBUG_EN
            fail_first_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            sig_q    <= sig_d;
            pat_q    <= pat_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
`ifdef GATE_BIST_DEBUG_EN
            fail_first_q <= fail_first_d;
`endif
        end
    end

    assign dut_in = dut_in_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign pass   = pass_q;
`ifdef GATE_BIST_DEBUG_EN
    assign dbg_sig        = sig_q;
    assign dbg_pat        = pat_q;
    assign dbg_fail_first = fail_first_q;
`endif

endmodule
